// File: rtl/nios_core_onchip_memory_ctrl.sv
// Parametrised Avalon-MM on-chip RAM: hardware clear after reset, pipelined reads with readdatavalid.
// Define ONCHIP_MEM_PARITY_EN to store even parity per byte lane and add parity_err/parity_err_sticky.
module nios_core_onchip_memory_ctrl #(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 16384,
  parameter int ADDR_W         = 14,
  parameter int OUT_REG        = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reset_req,
  input  logic                  clken,
  input  logic                  chipselect,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W/8-1:0]   byteenable,
  input  logic [DATA_W-1:0]     writedata,
  output logic [DATA_W-1:0]     readdata,
  output logic                  readdatavalid,
  output logic                  waitrequest,
  output logic                  init_done
`ifdef ONCHIP_MEM_PARITY_EN
  ,
  output logic                  parity_err,
  output logic                  parity_err_sticky
`endif
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

`ifdef ONCHIP_MEM_PARITY_EN
  function automatic logic [NB-1:0] lane_parity(input logic [DATA_W-1:0] d);
    logic [NB-1:0] p;
    p = {NB{1'b0}};
    for (int i = 0; i < NB; i++) begin
      p[i] = ^d[8*i +: 8];
    end
    return p;
  endfunction
`endif

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    clr_cnt_q, clr_cnt_d;
  logic                 init_done_q, init_done_d;

  logic                 wait_s;
  logic                 rd_acc_s;
  logic                 wr_acc_s;
  logic                 clear_we_s;

  logic                 mem_we_s;
  logic [ADDR_W-1:0]    mem_addr_s;
  logic [DATA_W-1:0]    mem_wdata_s;
  logic [NB-1:0]        mem_be_s;
  logic [DATA_W-1:0]    mem_q [DEPTH];

  logic                 s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0]    s1_data_q, s1_data_d;
  logic                 out_valid_s;
  logic [DATA_W-1:0]    out_data_s;

`ifdef ONCHIP_MEM_PARITY_EN
  logic [NB-1:0]        mem_wpar_s;
  logic [NB-1:0]        par_q [DEPTH];
  logic [NB-1:0]        s1_par_q, s1_par_d;
  logic [NB-1:0]        out_par_s;
  logic                 perr_s;
  logic                 sticky_q, sticky_d;
`endif

  // Reset is folded into waitrequest so nothing is committed on a reset edge.
  always_comb begin
    wait_s     = reset | (state_q != ST_RUN) | ~init_done_q | reset_req | ~clken;
    wr_acc_s   = chipselect & write & ~wait_s;
    rd_acc_s   = chipselect & read & ~write & ~wait_s;
    clear_we_s = ~reset & clken & (state_q == ST_CLEAR);
  end

  // Clear sequencer next state: one zero word per enabled cycle, leave on the last address.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    init_done_d = init_done_q;
    if (clken) begin
      case (state_q)
        ST_CLEAR: begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
          if (clr_cnt_q == LAST_ADDR) begin
            state_d     = ST_RUN;
            init_done_d = 1'b1;
          end else begin
            state_d     = ST_CLEAR;
            init_done_d = 1'b0;
          end
        end
        ST_RUN: begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
        default: begin
          state_d     = RESET_STATE;
          clr_cnt_d   = {ADDR_W{1'b0}};
          init_done_d = 1'b0;
        end
      endcase
    end else begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      init_done_d = init_done_q;
    end
  end

  // Sequencer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RESET_STATE;
      clr_cnt_q   <= {ADDR_W{1'b0}};
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= init_done_d;
    end
  end

  // Single write port shared by the clear sequencer and CPU writes.
  always_comb begin
    if (clear_we_s) begin
      mem_we_s    = 1'b1;
      mem_addr_s  = clr_cnt_q;
      mem_wdata_s = {DATA_W{1'b0}};
      mem_be_s    = {NB{1'b1}};
    end else begin
      mem_we_s    = wr_acc_s;
      mem_addr_s  = address;
      mem_wdata_s = writedata;
      mem_be_s    = byteenable;
    end
  end

  // Byte-lane array write.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be_s[i]) begin
          mem_q[mem_addr_s][8*i +: 8] <= mem_wdata_s[8*i +: 8];
        end
      end
    end
  end

`ifdef ONCHIP_MEM_PARITY_EN
  always_comb begin
    mem_wpar_s = lane_parity(mem_wdata_s);
  end

  // Parity write alongside each byte lane.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be_s[i]) begin
          par_q[mem_addr_s][i] <= mem_wpar_s[i];
        end
      end
    end
  end
`endif

  // First read stage: array access at the accepting edge; clken low holds everything.
  always_comb begin
    s1_valid_d = clken ? rd_acc_s : s1_valid_q;
    s1_data_d  = rd_acc_s ? mem_q[address] : s1_data_q;
`ifdef ONCHIP_MEM_PARITY_EN
    s1_par_d   = rd_acc_s ? par_q[address] : s1_par_q;
`endif
  end

  // First read stage registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= {DATA_W{1'b0}};
`ifdef ONCHIP_MEM_PARITY_EN
      s1_par_q   <= {NB{1'b0}};
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
`ifdef ONCHIP_MEM_PARITY_EN
      s1_par_q   <= s1_par_d;
`endif
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic              o_valid_q, o_valid_d;
    logic [DATA_W-1:0] o_data_q, o_data_d;
`ifdef ONCHIP_MEM_PARITY_EN
    logic [NB-1:0]     o_par_q, o_par_d;
`endif

    // Output stage only loads on a valid beat so readdata holds between reads.
    always_comb begin
      if (clken) begin
        o_valid_d = s1_valid_q;
        o_data_d  = s1_valid_q ? s1_data_q : o_data_q;
`ifdef ONCHIP_MEM_PARITY_EN
        o_par_d   = s1_valid_q ? s1_par_q : o_par_q;
`endif
      end else begin
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
`ifdef ONCHIP_MEM_PARITY_EN
        o_par_d   = o_par_q;
`endif
      end
    end

    // Output stage registers.
    always_ff @(posedge clk) begin
      if (reset) begin
        o_valid_q <= 1'b0;
        o_data_q  <= {DATA_W{1'b0}};
`ifdef ONCHIP_MEM_PARITY_EN
        o_par_q   <= {NB{1'b0}};
`endif
      end else begin
        o_valid_q <= o_valid_d;
        o_data_q  <= o_data_d;
`ifdef ONCHIP_MEM_PARITY_EN
        o_par_q   <= o_par_d;
`endif
      end
    end

    assign out_valid_s = o_valid_q;
    assign out_data_s  = o_data_q;
`ifdef ONCHIP_MEM_PARITY_EN
    assign out_par_s   = o_par_q;
`endif
  end else begin : g_no_out_reg
    assign out_valid_s = s1_valid_q;
    assign out_data_s  = s1_data_q;
`ifdef ONCHIP_MEM_PARITY_EN
    assign out_par_s   = s1_par_q;
`endif
  end

`ifdef ONCHIP_MEM_PARITY_EN
  // Parity check aligned with the visible readdatavalid beat.
  always_comb begin
    perr_s   = out_valid_s & clken & ~reset & (|(lane_parity(out_data_s) ^ out_par_s));
    sticky_d = sticky_q | perr_s;
  end

  // Sticky parity status, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign parity_err        = perr_s;
  assign parity_err_sticky = sticky_q;
`endif

  // A pending beat is masked while stalled or in reset so it is shown exactly once.
  assign readdata      = out_data_s;
  assign readdatavalid = out_valid_s & clken & ~reset;
  assign waitrequest   = wait_s;
  assign init_done     = init_done_q;

endmodule

// File: tb/tb_nios_core_onchip_memory_ctrl.sv
// Bench for nios_core_onchip_memory_ctrl: two instances (read latency 1 and 2) driven in lockstep
// and checked every cycle against a behavioural memory model with a queue of due read beats.
module tb_nios_core_onchip_memory_ctrl;
  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam int NB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, reset_req = 1'b0, clken = 1'b1;
  logic chipselect = 1'b0, read = 1'b0, write = 1'b0;
  logic [AW-1:0] address = '0;
  logic [NB-1:0] byteenable = '0;
  logic [DW-1:0] writedata = '0;

  logic [DW-1:0] rdata1, rdata0;
  logic rdv1, rdv0, wr1, wr0, idone1, idone0;
`ifdef ONCHIP_MEM_PARITY_EN
  logic perr1, perr0, sticky1, sticky0;
`endif

  nios_core_onchip_memory_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .OUT_REG(1), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken), .chipselect(chipselect),
    .read(read), .write(write), .address(address), .byteenable(byteenable), .writedata(writedata),
    .readdata(rdata1), .readdatavalid(rdv1), .waitrequest(wr1), .init_done(idone1)
`ifdef ONCHIP_MEM_PARITY_EN
    , .parity_err(perr1), .parity_err_sticky(sticky1)
`endif
  );

  nios_core_onchip_memory_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .OUT_REG(0), .CLEAR_ON_RESET(1)) dut0 (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken), .chipselect(chipselect),
    .read(read), .write(write), .address(address), .byteenable(byteenable), .writedata(writedata),
    .readdata(rdata0), .readdatavalid(rdv0), .waitrequest(wr0), .init_done(idone0)
`ifdef ONCHIP_MEM_PARITY_EN
    , .parity_err(perr0), .parity_err_sticky(sticky0)
`endif
  );

  typedef struct {
    int          due;
    logic [DW-1:0] data;
    bit          perr;
  } rd_t;

  rd_t q1[$];
  rd_t q0[$];
  logic [DW-1:0] mem_m [DEPTH];
  bit bad_m [DEPTH];
  int clr_left = DEPTH;
  int ecyc = 0;
  bit started = 0;
  bit sticky1_m = 0, sticky0_m = 0;
  int vectors = 0, miscompares = 0;
  int wait_cnt = 0, pulses0 = 0, pulses1 = 0;
  logic [DW-1:0] last_rd1 = '0, last_rd0 = '0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Per-cycle comparison of both instances against the model (inputs already applied).
  task automatic check_cycle();
    logic exp_wait, ev1, ev0;
    exp_wait = reset | (clr_left != 0) | reset_req | ~clken;
    ev1 = clken && !reset && (q1.size() > 0) && (q1[0].due == ecyc);
    ev0 = clken && !reset && (q0.size() > 0) && (q0[0].due == ecyc);
    chk("waitrequest_l2", {31'd0, wr1}, {31'd0, exp_wait});
    chk("waitrequest_l1", {31'd0, wr0}, {31'd0, exp_wait});
    chk("init_done_l2", {31'd0, idone1}, {31'd0, clr_left == 0});
    chk("init_done_l1", {31'd0, idone0}, {31'd0, clr_left == 0});
    chk("rdvalid_l2", {31'd0, rdv1}, {31'd0, ev1});
    chk("rdvalid_l1", {31'd0, rdv0}, {31'd0, ev0});
    if (ev1) chk("readdata_l2", rdata1, q1[0].data);
    if (ev0) chk("readdata_l1", rdata0, q0[0].data);
`ifdef ONCHIP_MEM_PARITY_EN
    chk("parity_err_l2", {31'd0, perr1}, {31'd0, ev1 && q1[0].perr});
    chk("parity_err_l1", {31'd0, perr0}, {31'd0, ev0 && q0[0].perr});
    chk("sticky_l2", {31'd0, sticky1}, {31'd0, sticky1_m});
    chk("sticky_l1", {31'd0, sticky0}, {31'd0, sticky0_m});
`endif
    if (!reset && wr1) wait_cnt++;
    if (rdv1) begin pulses1++; last_rd1 = rdata1; end
    if (rdv0) begin pulses0++; last_rd0 = rdata0; end
  endtask

  // Model of one clock edge, expressed in enabled-cycle time.
  task automatic model_edge();
    bit acc;
    if (reset) begin
      clr_left = DEPTH;
      q1.delete();
      q0.delete();
      sticky1_m = 0;
      sticky0_m = 0;
      started = 1;
    end else if (clken) begin
      if (q1.size() > 0 && q1[0].due == ecyc) begin
        if (q1[0].perr) sticky1_m = 1;
        void'(q1.pop_front());
      end
      if (q0.size() > 0 && q0[0].due == ecyc) begin
        if (q0[0].perr) sticky0_m = 1;
        void'(q0.pop_front());
      end
      ecyc++;
      acc = chipselect && (read || write) && !reset_req && (clr_left == 0);
      if (clr_left > 0) begin
        clr_left--;
        if (clr_left == 0) begin
          for (int i = 0; i < DEPTH; i++) begin
            mem_m[i] = '0;
            bad_m[i] = 0;
          end
        end
      end else if (acc) begin
        if (write) begin
          for (int b = 0; b < NB; b++) begin
            if (byteenable[b]) begin
              mem_m[address][8*b +: 8] = writedata[8*b +: 8];
              if (b == 2) bad_m[address] = 0;
            end
          end
        end else begin
          q1.push_back('{due: ecyc + 1, data: mem_m[address], perr: bad_m[address]});
          q0.push_back('{due: ecyc, data: mem_m[address], perr: bad_m[address]});
        end
      end
    end
  endtask

  task automatic cyc(input logic rst, input logic cs, input logic rd, input logic wr,
                     input logic [AW-1:0] a, input logic [NB-1:0] be, input logic [DW-1:0] wd,
                     input logic ce, input logic rr);
    @(negedge clk);
    reset = rst; chipselect = cs; read = rd; write = wr; address = a;
    byteenable = be; writedata = wd; clken = ce; reset_req = rr;
    #1;
    if (started) check_cycle();
    @(posedge clk);
    model_edge();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic do_wr(input logic [AW-1:0] a, input logic [NB-1:0] be, input logic [DW-1:0] d);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, a, be, d, 1'b1, 1'b0);
  endtask

  task automatic do_rd(input logic [AW-1:0] a);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, a, '0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    // Reset and observe reset values.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
    chk("readdata_reset_l2", rdata1, 32'h0);
    chk("readdata_reset_l1", rdata0, 32'h0);

    // Clear must hold off access for exactly DEPTH cycles.
    wait_cnt = 0;
    idle(20);
    chk("clear_cycles", wait_cnt, 32'd16);

    do_rd(4'd5);
    idle(3);
    chk("cleared_word", last_rd1, 32'h0);

    do_wr(4'd3, 4'b0101, 32'hAABBCCDD);
    do_rd(4'd3);
    idle(3);
    chk("byte_lane_readback", last_rd1, 32'h00BB00DD);

    for (int i = 0; i < 8; i++) do_wr(AW'(i), 4'hF, 32'h10 + DW'(i));
    pulses0 = 0;
    for (int i = 0; i < 8; i++) do_rd(AW'(i));
    idle(3);
    chk("b2b_pulses", pulses0, 32'd8);

    // Stream with a 3-cycle clken stall in the middle.
    pulses0 = 0;
    pulses1 = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        for (int s = 0; s < 3; s++) cyc(1'b0, 1'b1, 1'b1, 1'b0, AW'(i), '0, '0, 1'b0, 1'b0);
      end
      do_rd(AW'(i));
    end
    idle(3);
    chk("stall_pulses_l1", pulses0, 32'd8);
    chk("stall_pulses_l2", pulses1, 32'd8);

    // read and write together: write wins, no data beat.
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 4'hF, 32'hCAFE0002, 1'b1, 1'b0);
    do_rd(4'd2);
    do_wr(4'd6, 4'hF, 32'h600D0006);
    do_rd(4'd6);
    idle(3);
    chk("rd_after_wr", last_rd1, 32'h600D0006);

    // reset_req stalls a new read while the in-flight one completes.
    do_rd(4'd1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd2, '0, '0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd2, '0, '0, 1'b1, 1'b1);
    do_rd(4'd2);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      logic w;
      w = ($urandom_range(0, 2) == 0);
      cyc(1'b0, ($urandom_range(0, 4) != 0), ~w, w, AW'($urandom_range(0, DEPTH - 1)),
          NB'($urandom), DW'($urandom), ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0));
    end
    idle(3);

`ifdef ONCHIP_MEM_PARITY_EN
    do_wr(4'd9, 4'hF, 32'h12345678);
    #2;
    dut.mem_q[9][16] = ~dut.mem_q[9][16];
    dut0.mem_q[9][16] = ~dut0.mem_q[9][16];
    mem_m[9][16] = ~mem_m[9][16];
    bad_m[9] = 1;
    do_rd(4'd9);
    idle(3);
    chk("sticky_set", {31'd0, sticky1}, 32'd1);
`endif

    // Reset one cycle after a read accept: the beat is dropped and CLEAR reruns.
    do_wr(4'd7, 4'hF, 32'h00000077);
    pulses1 = 0;
    do_rd(4'd7);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
    wait_cnt = 0;
    idle(20);
    chk("reset_drops_beat", pulses1, 32'd0);
    chk("reclear_cycles", wait_cnt, 32'd16);
    do_rd(4'd7);
    idle(3);
    chk("post_reset_clear", last_rd1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nios_core_onchip_memory_ctrl.md
Name: nios_core_onchip_memory_ctrl

Overview:
- Parametrised on-chip RAM slave for the Nios core. Successor to the fixed 16K x 32 single-port memory.
- Generic data width and depth, and a pipelined Avalon-MM read path with readdatavalid and a selectable output register.
- Waitrequest-based back-pressure.
- Hardware clear state machine that zeroes the array after reset, before the CPU may access it.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- DEPTH, 16384, number of words; power of 2, at least 4.
- ADDR_W, 14, word address width; equals log2(DEPTH).
- OUT_REG, 1, 0 = read latency 1; 1 = read latency 2 (extra output register).
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = skip the clear.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- reset_req  in  1  reset request; when high, blocks new accesses
- clken  in  1  clock enable; when low, stalls the block
- chipselect  in  1  slave select
- read  in  1  read request
- write  in  1  write request
- address  in  ADDR_W  word address
- byteenable  in  DATA_W/8  byte lanes for writes
- writedata  in  DATA_W  write data
- readdata  out  DATA_W  read data; valid only while readdatavalid=1
- readdatavalid  out  1  one-cycle read-data strobe
- waitrequest  out  1  access not accepted this cycle
- init_done  out  1  array ready for access

Behaviour:
- Reset values:
  - readdata=0, readdatavalid=0, waitrequest=1, init_done=0.
  - Clear counter=0, all pipeline valid bits=0.
- FSM states:
  - CLEAR: entered on reset when CLEAR_ON_RESET=1.
    - Each cycle with clken=1: write all-zero word at the counter address, then increment the counter.
    - When counter=DEPTH-1 is written, go to RUN. The wrap is detected on the last address; the counter never overflows into ADDR_W+1 bits.
    - Clearing takes exactly DEPTH enabled cycles.
  - RUN: entered directly on reset when CLEAR_ON_RESET=0. init_done=1 from the first cycle after reset deasserts.
- waitrequest = (state!=RUN) | reset_req | ~clken.
- An access is accepted when chipselect & (read|write) & ~waitrequest.
- Write:
  - Committed at the accepting edge, per byteenable lane.
  - byteenable=0 writes nothing but is still accepted.
- Read:
  - Accepted at edge N; readdata/readdatavalid appear at edge N+1+OUT_REG.
  - Fully pipelined: one read accepted per cycle, no bubbles.
  - readdatavalid is a 1-cycle pulse per accepted read.
  - readdata holds its last value otherwise.
- read and write asserted together:
  - The write is performed; no readdatavalid is generated.
  - Flagged only by the assertion in the bench, not in RTL.
- Read-during-write to the same address in consecutive cycles: the read returns the new data, since the write commits before the read's array access.
- clken=0 freezes everything: pipeline registers, readdatavalid, FSM and clear counter all hold. No pending readdatavalid is lost or duplicated.
- reset_req=1: new accesses are stalled. In-flight reads still complete.
- Reset mid-operation (CLEAR or RUN): all in-flight reads are discarded with no readdatavalid. The FSM restarts, and CLEAR restarts from address 0.
- Array contents are unchanged by reset except through CLEAR.

Optional Feature:
- Macro ONCHIP_MEM_PARITY_EN.
- With the macro:
  - One even-parity bit is stored per byte lane and written with each byte and during CLEAR (parity of 0 = 0).
  - Parity is checked on read, aligned with readdatavalid.
  - Extra output port parity_err (1 bit, reset 0) pulses with readdatavalid when any lane mismatches.
  - A sticky status bit, cleared only by reset, is exposed as part of the same port set.
- Without the macro: no parity storage, no parity_err port, identical timing.

Test Plan:
- CLEAR timing: DEPTH=16, CLEAR_ON_RESET=1, release reset → waitrequest=1 for exactly 16 cycles. init_done=1 at cycle 16. Read addr 5 → readdata=0.
- Byte-lane write: write 0xAABBCCDD to addr 3 with byteenable=4'b0101 over a zeroed word, then read → 0x00BB00DD, with readdatavalid 2 cycles after accept (OUT_REG=1).
- Back-to-back reads: reads of addr 0..7 holding 0x10..0x17, OUT_REG=0 → eight consecutive readdatavalid pulses, data 0x10..0x17 in order, one cycle after each accept.
- Stall: drop clken for 3 cycles mid-stream → no readdatavalid during the stall. The full sequence resumes without loss or duplication. waitrequest=1 while clken=0.
- Reset mid-read: assert reset one cycle after a read accept → no readdatavalid. waitrequest=1 and CLEAR restarts at addr 0. Data written before reset reads back as 0 after CLEAR.
- Parity (ONCHIP_MEM_PARITY_EN): force-flip one stored bit of lane 2 via hierarchical write, then read → parity_err pulses with readdatavalid and the sticky bit sets.
